des_cmd_issuer: RTL and testbench
=================================

Name: des_cmd_issuer

Overview:
- Host-side initiator for the DES search block wrapper command protocol; the wrapper is the responder.
- Turns a single local job request into the full command sequence: RESTART, READ_REGION, START or TEST_MODE, result collection, final RESTART.
- Drives the four-phase cmd_valid/cmd_read handshake and the advance_test handshake.
- Synchronises the wrapper's status flags into the local clock domain and captures counter/ciphertext results.

Parameters:
- N, 32, region width; region output = zero-extended job_region[N-1:0]; 1..32.
- TIMEOUT, 1024, max cycles spent in any handshake state before aborting with timeout status; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- job_start  in  1  one-cycle pulse; accepted only in IDLE
- job_region  in  32  region to search/test
- job_test  in  1  0 = search job, 1 = test job; sampled with job_start
- job_test_count  in  16  number of test results to collect; 0 is treated as 1
- abort  in  1  one-cycle pulse; ends the current job
- job_busy  out  1  high from the cycle after acceptance until job_done
- job_done  out  1  one-cycle pulse at job end
- job_status  out  2  0 = OK, 1 = ABORTED, 2 = TIMEOUT; valid with job_done, held until the next job_start
- result_valid  out  1  one-cycle pulse per captured result
- result_index  out  16  result number, 0-based
- result_counter  out  64  captured wrapper counter
- result_ciphertext  out  64  captured wrapper ciphertext
- cmd  out  32  command code to the wrapper
- cmd_valid  out  1  command valid
- advance_test_cmd  out  1  test advance request
- region  out  32  region to the wrapper
- cmd_read  in  1  async; wrapper acknowledge
- cmd_read_data  in  32  echoed command; quasi-static while cmd_read is high
- test_res_ready  in  1  async
- done  in  1  async
- counter  in  64  quasi-static while done or test_res_ready is high
- ciphertext  in  64  quasi-static while done or test_res_ready is high

Behaviour:
- Synchroniser: cmd_read, test_res_ready and done each pass through a 2-flop synchroniser (sync_*). Data buses are sampled only when the corresponding sync flag is high.
- Reset values: all outputs 0, state IDLE, job_status 0.
- States:
  - IDLE
  - CMD_REQ: cmd and region driven, cmd_valid = 1.
  - CMD_REL: cmd_valid = 0, cmd held.
  - WAIT_DONE
  - WAIT_TRES
  - ADV_HOLD: advance_test_cmd = 1.
  - ADV_REL
  - DRAIN: all outputs to the wrapper 0; wait for sync_cmd_read = 0, then issue RESTART.
  - FIN
- Sequence:
  - step register selects the current command: RESTART, READ_REGION, START/TEST_MODE, final RESTART.
  - IDLE + job_start: latch region/mode/count, go to CMD_REQ with RESTART.
- CMD_REQ -> CMD_REL when sync_cmd_read = 1 and cmd_read_data == cmd. An echo mismatch keeps waiting.
- CMD_REL -> next step when sync_cmd_read = 0.
- After START: WAIT_DONE. On sync_done: capture counter/ciphertext, pulse result_valid with index 0, issue final RESTART.
- After TEST_MODE: WAIT_TRES.
  - On sync_test_res_ready: capture, pulse result_valid, go to ADV_HOLD.
  - If the index is the last one (count-1), issue the final RESTART instead of advancing.
  - ADV_HOLD -> ADV_REL when sync_test_res_ready = 0.
  - ADV_REL: advance_test_cmd = 0, increment index, go to WAIT_TRES.
- After the final RESTART handshake: FIN pulses job_done with status OK, then IDLE.
- Exactly one result per wrapper assertion. A flag still high on entry to WAIT_TRES counts as a new result only after it has been seen low (ADV_HOLD guarantees this).
- Timeout counter:
  - Reloads on every state change.
  - Counts only in CMD_REQ, CMD_REL, ADV_HOLD, ADV_REL and DRAIN.
  - Never counts in WAIT_DONE or WAIT_TRES; searches run for hours.
  - Expiry: status TIMEOUT, go to DRAIN. Expiry inside DRAIN or the final RESTART: drop outputs and finish straight to FIN.
- abort while busy: status ABORTED, go to DRAIN, issue RESTART, then FIN. abort in IDLE is ignored. abort during the final RESTART still completes that RESTART.
- job_start while busy is ignored.
- abort and job_start in the same cycle in IDLE: job accepted, abort ignored.
- cmd returns to 0 whenever cmd_valid is 0 outside CMD_REL.
- index wraps at 16 bits; not reachable for count ≤ 65535.

Decomposition:
- Package des_cmd_pkg:
  - CMD_READ_REGION = 1, CMD_START = 2, CMD_TEST_MODE = 3, CMD_RESTART = 4
  - STATUS_OK / ABORTED / TIMEOUT codes
  - state encoding
- Sub-module des_sync_bit (2-flop synchroniser), instantiated three times.

Test Plan:
- Search job, region = 0x5: bench wrapper model acks after 3 cycles and raises done with counter = 0x1234, ciphertext = 0xDEADBEEF00C0FFEE. Expect: cmd sequence 4, 1, 2, 4; region = 5 during the READ_REGION request; one result_valid with those values; job_done with status 0.
- Test job, count = 3: model returns ciphertexts 0xA, 0xB, 0xC. Expect: 3 result_valid pulses with indexes 0, 1, 2; exactly 2 advance_test_cmd pulses; final RESTART; status 0.
- Echo mismatch: cmd_read_data = 2 while cmd = 1 for 10 cycles, then correct. Expect: cmd_valid stays high until the correct echo, then completes normally.
- abort in WAIT_DONE. Expect: cmd_valid drops, RESTART issued, job_done with status 1, no result_valid.
- TIMEOUT = 16, model never acks. Expect: job_done with status 2 within 16 + 16 + 3 cycles; all wrapper outputs 0 afterwards.
- Reset mid-test-job. Expect: all outputs 0 the next cycle; IDLE; a new job_start is accepted.

Source files
------------

// File: rtl/des_cmd_pkg.sv
// Command codes, status codes and FSM encodings shared by the DES command issuer.
package des_cmd_pkg;

   localparam logic [31:0] CMD_READ_REGION = 32'd1;
   localparam logic [31:0] CMD_START       = 32'd2;
   localparam logic [31:0] CMD_TEST_MODE   = 32'd3;
   localparam logic [31:0] CMD_RESTART     = 32'd4;

   localparam logic [1:0] STATUS_OK      = 2'd0;
   localparam logic [1:0] STATUS_ABORTED = 2'd1;
   localparam logic [1:0] STATUS_TIMEOUT = 2'd2;

   typedef enum logic [3:0] {
      StIdle,
      StCmdReq,
      StCmdRel,
      StWaitDone,
      StWaitTres,
      StAdvHold,
      StAdvRel,
      StDrain,
      StFin
   } state_e;

   typedef enum logic [1:0] {
      StepRestart,
      StepRegion,
      StepGo,
      StepFinal
   } step_e;

   function automatic logic [31:0] step_cmd(input step_e step, input logic test);
      logic [31:0] c;
      case (step)
         StepRegion: c = CMD_READ_REGION;
         StepGo:     c = test ? CMD_TEST_MODE : CMD_START;
         default:    c = CMD_RESTART;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/des_sync_bit.sv
// Two-flop synchroniser for one asynchronous level from the wrapper.
module des_sync_bit (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/des_cmd_issuer.sv
// Host-side initiator: expands one job request into the wrapper command sequence
// and collects search/test results.
module des_cmd_issuer
   import des_cmd_pkg::*;
#(
   parameter int unsigned N       = 32,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        job_start,
   input  logic [31:0] job_region,
   input  logic        job_test,
   input  logic [15:0] job_test_count,
   input  logic        abort,
   output logic        job_busy,
   output logic        job_done,
   output logic [1:0]  job_status,
   output logic        result_valid,
   output logic [15:0] result_index,
   output logic [63:0] result_counter,
   output logic [63:0] result_ciphertext,
   output logic [31:0] cmd,
   output logic        cmd_valid,
   output logic        advance_test_cmd,
   output logic [31:0] region,
   input  logic        cmd_read,
   input  logic [31:0] cmd_read_data,
   input  logic        test_res_ready,
   input  logic        done,
   input  logic [63:0] counter,
   input  logic [63:0] ciphertext
);

   localparam logic [31:0] RegionMask = (N >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << N) - 64'd1);
   localparam logic [31:0] TmoLast    = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

   state_e      state_q, state_d;
   step_e       step_q, step_d;
   logic [31:0] region_q, region_d;
   logic        test_q, test_d;
   logic [15:0] last_q, last_d;
   logic [15:0] index_q, index_d;
   logic [1:0]  status_q, status_d;
   logic [31:0] tmo_q, tmo_d;
   logic        capture;

   logic        sync_cmd_read, sync_tres, sync_done;
   logic [31:0] cur_cmd;
   logic        in_cmd, timed, final_rst, expired;

   des_sync_bit u_sync_cmd_read (.clk(clk), .rst_n(rst_n), .d(cmd_read),       .q(sync_cmd_read));
   des_sync_bit u_sync_tres     (.clk(clk), .rst_n(rst_n), .d(test_res_ready), .q(sync_tres));
   des_sync_bit u_sync_done     (.clk(clk), .rst_n(rst_n), .d(done),           .q(sync_done));

   assign cur_cmd   = step_cmd(step_q, test_q);
   assign in_cmd    = (state_q == StCmdReq) || (state_q == StCmdRel);
   assign timed     = in_cmd || (state_q inside {StAdvHold, StAdvRel, StDrain});
   assign final_rst = in_cmd && (step_q == StepFinal);
   assign expired   = timed && (TIMEOUT != 0) && (tmo_q >= TmoLast);

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      region_d = region_q;
      test_d   = test_q;
      last_d   = last_q;
      index_d  = index_q;
      status_d = status_q;
      capture  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (job_start) begin
               region_d = job_region & RegionMask;
               test_d   = job_test;
               last_d   = (job_test_count == 16'd0) ? 16'd0 : job_test_count - 16'd1;
               index_d  = 16'd0;
               status_d = STATUS_OK;
               step_d   = StepRestart;
               state_d  = StCmdReq;
            end
         end
         StCmdReq: begin
            if (sync_cmd_read && (cmd_read_data == cur_cmd)) state_d = StCmdRel;
         end
         StCmdRel: begin
            if (!sync_cmd_read) begin
               unique case (step_q)
                  StepRestart: begin step_d = StepRegion; state_d = StCmdReq; end
                  StepRegion:  begin step_d = StepGo;     state_d = StCmdReq; end
                  StepGo: begin
                     index_d = 16'd0;
                     state_d = test_q ? StWaitTres : StWaitDone;
                  end
                  default:     state_d = StFin;
               endcase
            end
         end
         StWaitDone: begin
            if (sync_done) begin
               capture = 1'b1;
               step_d  = StepFinal;
               state_d = StCmdReq;
            end
         end
         StWaitTres: begin
            if (sync_tres) begin
               capture = 1'b1;
               if (index_q == last_q) begin
                  step_d  = StepFinal;
                  state_d = StCmdReq;
               end else begin
                  state_d = StAdvHold;
               end
            end
         end
         StAdvHold: begin
            if (!sync_tres) state_d = StAdvRel;
         end
         StAdvRel: begin
            index_d = index_q + 16'd1;
            state_d = StWaitTres;
         end
         StDrain: begin
            if (!sync_cmd_read) begin
               step_d  = StepFinal;
               state_d = StCmdReq;
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // The final RESTART always runs to completion; only a timeout cuts it short.
      if (!(state_q inside {StIdle, StFin})) begin
         if (abort && !final_rst && (state_q != StDrain)) begin
            status_d = STATUS_ABORTED;
            state_d  = StDrain;
            capture  = 1'b0;
         end else if (expired) begin
            status_d = STATUS_TIMEOUT;
            state_d  = (final_rst || (state_q == StDrain)) ? StFin : StDrain;
         end
      end

      if (state_d != state_q) tmo_d = 32'd0;
      else if (timed)         tmo_d = tmo_q + 32'd1;
      else                    tmo_d = tmo_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q           <= StIdle;
         step_q            <= StepRestart;
         region_q          <= 32'd0;
         test_q            <= 1'b0;
         last_q            <= 16'd0;
         index_q           <= 16'd0;
         status_q          <= STATUS_OK;
         tmo_q             <= 32'd0;
         result_valid      <= 1'b0;
         result_index      <= 16'd0;
         result_counter    <= 64'd0;
         result_ciphertext <= 64'd0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         region_q     <= region_d;
         test_q       <= test_d;
         last_q       <= last_d;
         index_q      <= index_d;
         status_q     <= status_d;
         tmo_q        <= tmo_d;
         result_valid <= capture;
         if (capture) begin
            result_index      <= index_q;
            result_counter    <= counter;
            result_ciphertext <= ciphertext;
         end
      end
   end

   assign cmd_valid        = (state_q == StCmdReq);
   assign cmd              = in_cmd ? cur_cmd : 32'd0;
   assign region           = in_cmd ? region_q : 32'd0;
   assign advance_test_cmd = (state_q == StAdvHold);
   assign job_busy         = !(state_q inside {StIdle, StFin});
   assign job_done         = (state_q == StFin);
   assign job_status       = status_q;

endmodule

// File: tb/tb_des_cmd_issuer.sv
// Directed bench for des_cmd_issuer with a behavioural DES wrapper responder.
module tb_des_cmd_issuer;

   logic        clk;
   logic        rst_n;
   logic        job_start, job_test, abort;
   logic [31:0] job_region;
   logic [15:0] job_test_count;
   logic        job_busy, job_done, result_valid, cmd_valid, advance_test_cmd;
   logic [1:0]  job_status;
   logic [15:0] result_index;
   logic [63:0] result_counter, result_ciphertext;
   logic [31:0] cmd, region;
   logic        cmd_read, test_res_ready, done;
   logic [31:0] cmd_read_data;
   logic [63:0] counter, ciphertext;

   int n_checks = 0;
   int n_pass   = 0;

   des_cmd_issuer #(.N(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .job_start(job_start), .job_region(job_region), .job_test(job_test),
      .job_test_count(job_test_count), .abort(abort),
      .job_busy(job_busy), .job_done(job_done), .job_status(job_status),
      .result_valid(result_valid), .result_index(result_index),
      .result_counter(result_counter), .result_ciphertext(result_ciphertext),
      .cmd(cmd), .cmd_valid(cmd_valid), .advance_test_cmd(advance_test_cmd),
      .region(region), .cmd_read(cmd_read), .cmd_read_data(cmd_read_data),
      .test_res_ready(test_res_ready), .done(done),
      .counter(counter), .ciphertext(ciphertext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wrapper model configuration (written only by the stimulus process)
   bit          m_ack_en     = 1'b1;
   int          m_bad_cfg    = 0;
   int          m_done_delay = 5;
   logic [63:0] m_cts [4];

   int ack_cnt, bad_cnt, done_dly, tidx;
   bit adv_seen;

   always @(posedge clk) begin
      if (!rst_n) begin
         cmd_read <= 1'b0; cmd_read_data <= 32'd0; done <= 1'b0; test_res_ready <= 1'b0;
         counter <= 64'd0; ciphertext <= 64'd0;
         ack_cnt <= 0; bad_cnt <= 0; done_dly <= 0; tidx <= 0; adv_seen <= 1'b0;
      end else begin
         if (done_dly > 0) begin
            done_dly <= done_dly - 1;
            if (done_dly == 1) begin
               done <= 1'b1; counter <= 64'h1234; ciphertext <= 64'hDEADBEEF00C0FFEE;
            end
         end
         if (advance_test_cmd && test_res_ready) begin
            test_res_ready <= 1'b0; adv_seen <= 1'b1;
         end else if (!advance_test_cmd && adv_seen && tidx < 4) begin
            test_res_ready <= 1'b1; ciphertext <= m_cts[tidx]; counter <= 64'(tidx);
            tidx <= tidx + 1; adv_seen <= 1'b0;
         end
         if (cmd_valid && !cmd_read) begin
            if (m_ack_en) begin
               if (ack_cnt == 2) begin
                  cmd_read <= 1'b1; ack_cnt <= 0;
                  if (cmd == 32'd1 && m_bad_cfg > 0) begin
                     cmd_read_data <= 32'd2; bad_cnt <= m_bad_cfg - 1;
                  end else begin
                     cmd_read_data <= cmd;
                  end
               end else begin
                  ack_cnt <= ack_cnt + 1;
               end
            end
         end else if (cmd_valid && cmd_read) begin
            if (bad_cnt > 0) bad_cnt <= bad_cnt - 1;
            else             cmd_read_data <= cmd;
         end else if (!cmd_valid && cmd_read) begin
            cmd_read <= 1'b0;
            case (cmd_read_data)
               32'd2: done_dly <= m_done_delay;
               32'd3: begin
                  test_res_ready <= 1'b1; ciphertext <= m_cts[0]; counter <= 64'd0; tidx <= 1;
               end
               32'd4: begin
                  done <= 1'b0; test_res_ready <= 1'b0; done_dly <= 0; adv_seen <= 1'b0;
               end
               default: ;
            endcase
         end else begin
            ack_cnt <= 0;
         end
      end
   end

   // Event recorders; tasks take snapshots and compare deltas
   logic        prev_valid = 1'b0, prev_adv = 1'b0;
   int          cmd_n = 0, res_n = 0, adv_n = 0, rr_len = 0;
   logic [31:0] cmd_log [128];
   logic [31:0] rr_region = 32'd0;
   logic [15:0] res_idx [32];
   logic [63:0] res_ctr [32];
   logic [63:0] res_ct  [32];

   always @(posedge clk) begin
      prev_valid <= cmd_valid;
      prev_adv   <= advance_test_cmd;
      if (cmd_valid && !prev_valid && cmd_n < 128) begin
         cmd_log[cmd_n] <= cmd;
         cmd_n <= cmd_n + 1;
         if (cmd == 32'd1) rr_region <= region;
      end
      if (cmd_valid && cmd == 32'd1) rr_len <= prev_valid ? rr_len + 1 : 1;
      if (advance_test_cmd && !prev_adv) adv_n <= adv_n + 1;
      if (result_valid && res_n < 32) begin
         res_idx[res_n] <= result_index;
         res_ctr[res_n] <= result_counter;
         res_ct[res_n]  <= result_ciphertext;
         res_n <= res_n + 1;
      end
   end

   task automatic start_job(input logic [31:0] rg, input logic tst, input logic [15:0] cnt,
                            input logic ab);
      @(negedge clk);
      job_start = 1'b1; job_region = rg; job_test = tst; job_test_count = cnt; abort = ab;
      @(negedge clk);
      job_start = 1'b0; abort = 1'b0;
   endtask

   // elapsed = cycles since the acceptance edge at which job_done was seen
   task automatic wait_done(input int limit, output bit ok, output logic [1:0] st,
                            output int elapsed);
      ok = 1'b0; st = 2'd3; elapsed = 1;
      while (!ok && elapsed < limit) begin
         @(negedge clk);
         elapsed++;
         if (job_done) begin ok = 1'b1; st = job_status; end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; job_start = 1'b0; abort = 1'b0; job_test = 1'b0;
      job_region = 32'd0; job_test_count = 16'd0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({cmd_valid, advance_test_cmd, job_busy, job_done, result_valid} !== 5'd0)
         $display("FAIL reset_ctrl: got %b want 00000",
                  {cmd_valid, advance_test_cmd, job_busy, job_done, result_valid});
      else n_pass++;
      n_checks++;
      if (cmd !== 32'd0) $display("FAIL reset_cmd: got %h want 0", cmd); else n_pass++;
      n_checks++;
      if (region !== 32'd0) $display("FAIL reset_region: got %h want 0", region); else n_pass++;
      n_checks++;
      if (job_status !== 2'd0) $display("FAIL reset_status: got %0d want 0", job_status);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_search();
      int c0, r0, el; bit ok; logic [1:0] st;
      c0 = cmd_n; r0 = res_n;
      start_job(32'h5, 1'b0, 16'd0, 1'b0);
      n_checks++;
      if (job_busy !== 1'b1) $display("FAIL search_busy: got %b want 1", job_busy); else n_pass++;
      wait_done(400, ok, st, el);
      n_checks++;
      if (!ok || st !== 2'd0) $display("FAIL search_done: got ok=%0d st=%0d want ok=1 st=0", ok, st);
      else n_pass++;
      n_checks++;
      if ({cmd_log[c0], cmd_log[c0+1], cmd_log[c0+2], cmd_log[c0+3]} !==
          {32'd4, 32'd1, 32'd2, 32'd4} || cmd_n - c0 != 4)
         $display("FAIL search_cmds: got n=%0d %h want n=4 4,1,2,4", cmd_n - c0,
                  {cmd_log[c0], cmd_log[c0+1], cmd_log[c0+2], cmd_log[c0+3]});
      else n_pass++;
      n_checks++;
      if (rr_region !== 32'd5) $display("FAIL search_region: got %h want 5", rr_region);
      else n_pass++;
      n_checks++;
      if (rr_len != 6) $display("FAIL search_rr_len: got %0d want 6", rr_len); else n_pass++;
      n_checks++;
      if (res_n - r0 != 1 || res_idx[r0] !== 16'd0)
         $display("FAIL search_results: got n=%0d idx=%0d want n=1 idx=0", res_n - r0, res_idx[r0]);
      else n_pass++;
      n_checks++;
      if (res_ctr[r0] !== 64'h1234 || res_ct[r0] !== 64'hDEADBEEF00C0FFEE)
         $display("FAIL search_data: got %h/%h want 1234/deadbeef00c0ffee", res_ctr[r0], res_ct[r0]);
      else n_pass++;
      n_checks++;
      if (job_busy !== 1'b0 || job_status !== 2'd0)
         $display("FAIL search_idle: got busy=%b st=%0d want 0/0", job_busy, job_status);
      else n_pass++;
   endtask

   task automatic test_test_mode();
      int c0, r0, a0, el; bit ok; logic [1:0] st;
      c0 = cmd_n; r0 = res_n; a0 = adv_n;
      m_cts[0] = 64'hA; m_cts[1] = 64'hB; m_cts[2] = 64'hC; m_cts[3] = 64'hD;
      start_job(32'h77, 1'b1, 16'd3, 1'b0);
      wait_done(600, ok, st, el);
      n_checks++;
      if (!ok || st !== 2'd0) $display("FAIL test_done: got ok=%0d st=%0d want ok=1 st=0", ok, st);
      else n_pass++;
      n_checks++;
      if (res_n - r0 != 3) $display("FAIL test_count: got %0d want 3", res_n - r0); else n_pass++;
      n_checks++;
      if ({res_idx[r0], res_idx[r0+1], res_idx[r0+2]} !== {16'd0, 16'd1, 16'd2})
         $display("FAIL test_idx: got %h want 000000010002",
                  {res_idx[r0], res_idx[r0+1], res_idx[r0+2]});
      else n_pass++;
      n_checks++;
      if ({res_ct[r0], res_ct[r0+1], res_ct[r0+2]} !== {64'hA, 64'hB, 64'hC})
         $display("FAIL test_ct: got %h %h %h want a b c", res_ct[r0], res_ct[r0+1], res_ct[r0+2]);
      else n_pass++;
      n_checks++;
      if (adv_n - a0 != 2) $display("FAIL test_adv: got %0d want 2", adv_n - a0); else n_pass++;
      n_checks++;
      if ({cmd_log[c0], cmd_log[c0+1], cmd_log[c0+2], cmd_log[c0+3]} !==
          {32'd4, 32'd1, 32'd3, 32'd4} || cmd_n - c0 != 4)
         $display("FAIL test_cmds: got n=%0d %h want n=4 4,1,3,4", cmd_n - c0,
                  {cmd_log[c0], cmd_log[c0+1], cmd_log[c0+2], cmd_log[c0+3]});
      else n_pass++;
   endtask

   task automatic test_echo_mismatch();
      int r0, el; bit ok; logic [1:0] st;
      r0 = res_n;
      m_bad_cfg = 10;
      start_job(32'h9, 1'b0, 16'd0, 1'b0);
      wait_done(400, ok, st, el);
      m_bad_cfg = 0;
      n_checks++;
      if (rr_len != 14) $display("FAIL echo_hold: got %0d want 14", rr_len); else n_pass++;
      n_checks++;
      if (!ok || st !== 2'd0) $display("FAIL echo_done: got ok=%0d st=%0d want ok=1 st=0", ok, st);
      else n_pass++;
      n_checks++;
      if (res_n - r0 != 1) $display("FAIL echo_result: got %0d want 1", res_n - r0); else n_pass++;
   endtask

   task automatic test_abort();
      int c0, r0, el, w; bit ok; logic [1:0] st;
      c0 = cmd_n; r0 = res_n;
      m_done_delay = 1000;
      start_job(32'h3, 1'b0, 16'd0, 1'b0);
      w = 0;
      while (cmd_n - c0 < 3 && w < 200) begin @(negedge clk); w++; end
      repeat (20) @(negedge clk);
      n_checks++;
      if (job_busy !== 1'b1 || cmd_valid !== 1'b0)
         $display("FAIL abort_pre: got busy=%b valid=%b want 1/0", job_busy, cmd_valid);
      else n_pass++;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if (cmd_valid !== 1'b0 || job_busy !== 1'b1)
         $display("FAIL abort_drain: got valid=%b busy=%b want 0/1", cmd_valid, job_busy);
      else n_pass++;
      wait_done(200, ok, st, el);
      m_done_delay = 5;
      n_checks++;
      if (!ok || st !== 2'd1) $display("FAIL abort_status: got ok=%0d st=%0d want ok=1 st=1", ok, st);
      else n_pass++;
      n_checks++;
      if (cmd_n - c0 != 4 || cmd_log[c0+3] !== 32'd4)
         $display("FAIL abort_restart: got n=%0d last=%0d want n=4 last=4", cmd_n - c0,
                  cmd_log[c0+3]);
      else n_pass++;
      n_checks++;
      if (res_n != r0) $display("FAIL abort_noresult: got %0d want 0", res_n - r0); else n_pass++;
   endtask

   task automatic test_timeout();
      int c0, el; bit ok; logic [1:0] st;
      c0 = cmd_n;
      m_ack_en = 1'b0;
      start_job(32'h1, 1'b0, 16'd0, 1'b0);
      wait_done(100, ok, st, el);
      m_ack_en = 1'b1;
      n_checks++;
      if (!ok || st !== 2'd2) $display("FAIL tmo_status: got ok=%0d st=%0d want ok=1 st=2", ok, st);
      else n_pass++;
      n_checks++;
      if (el > 35) $display("FAIL tmo_latency: got %0d cycles want <= 35", el); else n_pass++;
      n_checks++;
      if (cmd_n - c0 != 2 || cmd_log[c0] !== 32'd4 || cmd_log[c0+1] !== 32'd4)
         $display("FAIL tmo_cmds: got n=%0d want n=2 both 4", cmd_n - c0);
      else n_pass++;
      n_checks++;
      if ({cmd_valid, advance_test_cmd} !== 2'b00 || cmd !== 32'd0 || region !== 32'd0)
         $display("FAIL tmo_outputs: got v=%b a=%b cmd=%h rg=%h want all 0", cmd_valid,
                  advance_test_cmd, cmd, region);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int r0, w, el; bit ok; logic [1:0] st;
      r0 = res_n;
      start_job(32'h44, 1'b1, 16'd3, 1'b0);
      w = 0;
      while (res_n == r0 && w < 300) begin @(negedge clk); w++; end
      n_checks++;
      if (res_n == r0) $display("FAIL rstmid_progress: got 0 results want >= 1"); else n_pass++;
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({cmd_valid, advance_test_cmd, job_busy, job_done, result_valid} !== 5'd0 ||
          cmd !== 32'd0 || region !== 32'd0 || job_status !== 2'd0)
         $display("FAIL rstmid_outputs: got ctl=%b cmd=%h rg=%h st=%0d want all 0",
                  {cmd_valid, advance_test_cmd, job_busy, job_done, result_valid}, cmd, region,
                  job_status);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      start_job(32'h6, 1'b0, 16'd0, 1'b0);
      n_checks++;
      if (job_busy !== 1'b1) $display("FAIL rstmid_accept: got busy=%b want 1", job_busy);
      else n_pass++;
      wait_done(400, ok, st, el);
      n_checks++;
      if (!ok || st !== 2'd0) $display("FAIL rstmid_done: got ok=%0d st=%0d want ok=1 st=0", ok, st);
      else n_pass++;
   endtask

   task automatic test_idle_abort();
      int r0, el; bit ok; logic [1:0] st;
      r0 = res_n;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if (job_busy !== 1'b0 || job_status !== 2'd0)
         $display("FAIL idle_abort: got busy=%b st=%0d want 0/0", job_busy, job_status);
      else n_pass++;
      start_job(32'h8, 1'b0, 16'd0, 1'b1);
      wait_done(400, ok, st, el);
      n_checks++;
      if (!ok || st !== 2'd0) $display("FAIL start_abort: got ok=%0d st=%0d want ok=1 st=0", ok, st);
      else n_pass++;
      n_checks++;
      if (res_n - r0 != 1) $display("FAIL start_abort_res: got %0d want 1", res_n - r0);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_search();
      test_test_mode();
      test_echo_mismatch();
      test_abort();
      test_timeout();
      test_reset_mid();
      test_idle_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
